// File: rtl/load_unit_pkg.sv
// load_unit_pkg
//   Shared constants for the load path: datapath width, the load opcode,
//   the funct3 width/sign encodings and the 2-bit FSM state encoding.
package load_unit_pkg;

    localparam int XLEN_DEF = 32;

    localparam logic [6:0] OPC_LOAD = 7'b0000011;

    localparam logic [2:0] FNC_LB  = 3'b000;
    localparam logic [2:0] FNC_LH  = 3'b001;
    localparam logic [2:0] FNC_LW  = 3'b010;
    localparam logic [2:0] FNC_LBU = 3'b100;
    localparam logic [2:0] FNC_LHU = 3'b101;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } lu_state_t;

endpackage

// File: rtl/load_data_extract.sv
// load_data_extract
//   Combinational lane select for loads: picks the addressed byte/halfword
//   out of a memory word and sign- or zero-extends it. Also flags accesses
//   that are misaligned for their width or use an unknown funct3.
// Ports:
//   i_funct3  load width/sign
//   i_sft     byte offset within the word (addr[1:0])
//   i_word    word read from memory
//   o_result  extended load value
//   o_err     misaligned access or illegal funct3
module load_data_extract
    import load_unit_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic [2:0]      i_funct3,
    input  logic [1:0]      i_sft,
    input  logic [XLEN-1:0] i_word,
    output logic [XLEN-1:0] o_result,
    output logic            o_err
);

    logic [XLEN-1:0] w_shifted;
    logic [7:0]      w_byte;
    logic [15:0]     w_half;

    // Shift the addressed lane down to bit 0; halfword at sft==3 would
    // straddle the word and is rejected below, so its data is don't-care.
    assign w_shifted = i_word >> {i_sft, 3'b000};
    assign w_byte    = w_shifted[7:0];
    assign w_half    = w_shifted[15:0];

    always_comb begin
        o_result = '0;
        o_err    = 1'b0;
        case (i_funct3)
            FNC_LB:  o_result = {{(XLEN-8){w_byte[7]}}, w_byte};
            FNC_LBU: o_result = {{(XLEN-8){1'b0}}, w_byte};
            FNC_LH: begin
                o_result = {{(XLEN-16){w_half[15]}}, w_half};
                o_err    = (i_sft == 2'd3);
            end
            FNC_LHU: begin
                o_result = {{(XLEN-16){1'b0}}, w_half};
                o_err    = (i_sft == 2'd3);
            end
            FNC_LW: begin
                o_result = i_word;
                o_err    = (i_sft != 2'd0);
            end
            default: o_err = 1'b1;
        endcase
    end

endmodule

// File: rtl/load_unit.sv
// load_unit
//   Single-outstanding load engine between the EX/MEM register and the data
//   memory read port. Issues a word-aligned read, waits RD_LATENCY edges,
//   extracts/extends the addressed lane and returns a one-cycle response.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   flush                 kill any in-flight load (no response)
//   req_valid/req_ready   request handshake (ready only when idle)
//   opcode, funct3, addr  load request fields
//   mem_re, mem_addr      read strobe / word-aligned address to memory
//   mem_rdata             read data from memory
//   resp_valid            one-cycle result strobe
//   resp_data, resp_err   result and error flag, held until next response
module load_unit
    import load_unit_pkg::*;
#(
    parameter int XLEN       = XLEN_DEF,
    parameter int RD_LATENCY = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [6:0]      opcode,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] addr,
    output logic            mem_re,
    output logic [XLEN-1:0] mem_addr,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_data,
    output logic            resp_err
);

    localparam logic [2:0] LAT = 3'(RD_LATENCY);

    lu_state_t       r_state;
    logic [2:0]      r_cnt;
    logic [2:0]      r_funct3;
    logic [1:0]      r_sft;
    logic            r_resp_valid;
    logic [XLEN-1:0] r_resp_data;
    logic            r_resp_err;

    logic            w_idle;
    logic            w_accept;
    logic [2:0]      w_ex_f3;
    logic [1:0]      w_ex_sft;
    logic [XLEN-1:0] w_ex_result;
    logic            w_ex_err;

    assign w_idle    = (r_state == ST_IDLE);
    // rst_n gates ready so nothing looks acceptable while held in reset.
    assign req_ready = rst_n & w_idle & ~flush;
    assign w_accept  = req_valid & req_ready & (opcode == OPC_LOAD);

    // One extractor serves both uses: in IDLE it legality-checks the live
    // request, in WAIT it formats the returning word with the captured fields.
    assign w_ex_f3  = w_idle ? funct3     : r_funct3;
    assign w_ex_sft = w_idle ? addr[1:0]  : r_sft;

    load_data_extract #(.XLEN(XLEN)) u_extract (
        .i_funct3 (w_ex_f3),
        .i_sft    (w_ex_sft),
        .i_word   (mem_rdata),
        .o_result (w_ex_result),
        .o_err    (w_ex_err)
    );

    assign mem_re     = w_accept & ~w_ex_err;
    assign mem_addr   = {addr[XLEN-1:2], 2'b00};
    assign resp_valid = r_resp_valid;
    assign resp_data  = r_resp_data;
    assign resp_err   = r_resp_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_funct3     <= '0;
            r_sft        <= '0;
            r_resp_valid <= 1'b0;
            r_resp_data  <= '0;
            r_resp_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_resp_valid <= 1'b0;
                    if (w_accept) begin
                        r_funct3 <= funct3;
                        r_sft    <= addr[1:0];
                        if (w_ex_err) begin
                            // Illegal access never touches memory.
                            r_state      <= ST_RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b1;
                            r_resp_data  <= '0;
                        end else begin
                            r_state <= ST_WAIT;
                            r_cnt   <= LAT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (flush) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                    end else if (r_cnt == 3'd1) begin
                        r_resp_data  <= w_ex_result;
                        r_resp_err   <= 1'b0;
                        r_resp_valid <= 1'b1;
                        r_state      <= ST_RESP;
                        r_cnt        <= '0;
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                ST_RESP: begin
                    r_resp_valid <= 1'b0;
                    r_state      <= ST_IDLE;
                end
                default: begin
                    r_resp_valid <= 1'b0;
                    r_state      <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_unit.sv
module tb_load_unit;
    import load_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        req_valid;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] mem_rdata;

    logic        rdy1, re1, rv1, err1;
    logic [31:0] maddr1, rd1;
    logic        rdy3, re3, rv3, err3;
    logic [31:0] maddr3, rd3;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    load_unit #(.XLEN(32), .RD_LATENCY(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .req_valid(req_valid), .req_ready(rdy1),
        .opcode(opcode), .funct3(funct3), .addr(addr),
        .mem_re(re1), .mem_addr(maddr1), .mem_rdata(mem_rdata),
        .resp_valid(rv1), .resp_data(rd1), .resp_err(err1)
    );

    load_unit #(.XLEN(32), .RD_LATENCY(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .req_valid(req_valid), .req_ready(rdy3),
        .opcode(opcode), .funct3(funct3), .addr(addr),
        .mem_re(re3), .mem_addr(maddr3), .mem_rdata(mem_rdata),
        .resp_valid(rv3), .resp_data(rd3), .resp_err(err3)
    );

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] d;
        logic        e;
    } vec_t;

    vec_t vt[0:13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    // Full load on the RD_LATENCY=1 instance: issue, then check every cycle
    // up to one past the expected response strobe.
    task automatic do_load(input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] exp_d, input logic exp_e);
        int lat;
        lat = exp_e ? 1 : 2;
        @(negedge clk);
        req_valid = 1'b1; opcode = OPC_LOAD; funct3 = f3; addr = a;
        #1;
        chk("req_ready_at_issue", rdy1, 1);
        chk("mem_re_at_issue", re1, !exp_e);
        if (!exp_e) chk("mem_addr", maddr1, {a[31:2], 2'b00});
        @(posedge clk);
        for (int k = 1; k <= lat + 1; k++) begin
            @(negedge clk);
            if (k == 1) req_valid = 1'b0;
            #1;
            chk($sformatf("resp_valid_k%0d", k), rv1, (k == lat));
            chk($sformatf("mem_re_k%0d", k), re1, 0);
            if (k == lat) begin
                chk("resp_data", rd1, exp_d);
                chk("resp_err", err1, exp_e);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1);
    end

    initial begin
        vt[0]  = '{FNC_LB,  32'h1003, 32'hFFFF_FF88, 1'b0};
        vt[1]  = '{FNC_LBU, 32'h1001, 32'h0000_00AA, 1'b0};
        vt[2]  = '{FNC_LH,  32'h1002, 32'hFFFF_8899, 1'b0};
        vt[3]  = '{FNC_LHU, 32'h1001, 32'h0000_99AA, 1'b0};
        vt[4]  = '{FNC_LW,  32'h1000, 32'h8899_AABB, 1'b0};
        vt[5]  = '{FNC_LB,  32'h1000, 32'hFFFF_FFBB, 1'b0};
        vt[6]  = '{FNC_LBU, 32'h1002, 32'h0000_0099, 1'b0};
        vt[7]  = '{FNC_LH,  32'h1000, 32'hFFFF_AABB, 1'b0};
        vt[8]  = '{FNC_LHU, 32'h1002, 32'h0000_8899, 1'b0};
        vt[9]  = '{FNC_LH,  32'h1003, 32'h0000_0000, 1'b1};
        vt[10] = '{FNC_LW,  32'h1002, 32'h0000_0000, 1'b1};
        vt[11] = '{3'b011,  32'h1000, 32'h0000_0000, 1'b1};
        vt[12] = '{FNC_LHU, 32'h1003, 32'h0000_0000, 1'b1};
        vt[13] = '{3'b110,  32'h1001, 32'h0000_0000, 1'b1};

        // Reset state, with a load request pending to prove it is ignored.
        rst_n = 1'b0; flush = 1'b0;
        req_valid = 1'b1; opcode = OPC_LOAD; funct3 = FNC_LW; addr = 32'h1000;
        mem_rdata = 32'h8899_AABB;
        repeat (2) @(negedge clk);
        chk("rst_resp_valid", rv1, 0);
        chk("rst_resp_data", rd1, 0);
        chk("rst_resp_err", err1, 0);
        chk("rst_req_ready", rdy1, 0);
        chk("rst_mem_re", re1, 0);
        chk("rst_resp_valid3", rv3, 0);
        rst_n = 1'b1; req_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", rdy1, 1);

        for (int i = 0; i <= 13; i++)
            do_load(vt[i].f3, vt[i].a, vt[i].d, vt[i].e);

        // RD_LATENCY=3 with a back-to-back request held high.
        repeat (6) @(negedge clk);
        req_valid = 1'b1; opcode = OPC_LOAD; funct3 = FNC_LW; addr = 32'h2004;
        #1;
        chk("l3_ready", rdy3, 1);
        chk("l3_mem_re", re3, 1);
        chk("l3_mem_addr", maddr3, 32'h2004);
        @(posedge clk);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            #1;
            if (k <= 4) begin
                chk($sformatf("l3_resp_valid_k%0d", k), rv3, (k == 4));
                chk($sformatf("l3_ready_k%0d", k), rdy3, 0);
                chk($sformatf("l3_mem_re_k%0d", k), re3, 0);
            end
            if (k == 4) chk("l3_resp_data", rd3, 32'h8899_AABB);
            if (k == 5) begin
                chk("l3_ready_again", rdy3, 1);
                chk("l3_second_mem_re", re3, 1);
            end
        end
        @(posedge clk);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k == 1) begin
                req_valid = 1'b0;
                mem_rdata = 32'hCAFE_F00D;
            end
            #1;
            chk($sformatf("l3b_resp_valid_k%0d", k), rv3, (k == 4));
            if (k == 4) chk("l3b_resp_data", rd3, 32'hCAFE_F00D);
        end
        repeat (4) @(negedge clk);

        // Flush during WAIT: that load never responds.
        mem_rdata = 32'h8899_AABB;
        req_valid = 1'b1; opcode = OPC_LOAD; funct3 = FNC_LB; addr = 32'h1003;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0; flush = 1'b1;
        #1;
        chk("flush_ready", rdy1, 0);
        chk("flush_rv_k1", rv1, 0);
        @(negedge clk);
        flush = 1'b0;
        for (int k = 2; k <= 6; k++) begin
            @(negedge clk);
            chk($sformatf("flush_rv1_k%0d", k), rv1, 0);
            chk($sformatf("flush_rv3_k%0d", k), rv3, 0);
        end
        mem_rdata = 32'h0000_007F;
        do_load(FNC_LB, 32'h1000, 32'h0000_007F, 1'b0);

        // Flush in IDLE wins over a valid request.
        @(negedge clk);
        flush = 1'b1;
        req_valid = 1'b1; opcode = OPC_LOAD; funct3 = FNC_LW; addr = 32'h1000;
        #1;
        chk("idle_flush_mem_re", re1, 0);
        chk("idle_flush_ready", rdy1, 0);
        @(negedge clk);
        flush = 1'b0; req_valid = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            chk($sformatf("idle_flush_rv_k%0d", k), rv1, 0);
        end

        // Reset in the middle of a load.
        mem_rdata = 32'h8899_AABB;
        @(negedge clk);
        req_valid = 1'b1; opcode = OPC_LOAD; funct3 = FNC_LW; addr = 32'h1000;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0; rst_n = 1'b0;
        #1;
        chk("mid_rst_rv", rv1, 0);
        chk("mid_rst_ready", rdy1, 0);
        chk("mid_rst_data", rd1, 0);
        @(negedge clk);
        chk("mid_rst_rv_2", rv1, 0);
        chk("mid_rst_ready_2", rdy1, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("after_rst_ready", rdy1, 1);
        chk("after_rst_rv", rv1, 0);
        do_load(FNC_LW, 32'h1000, 32'h8899_AABB, 1'b0);

        // Non-load opcode is ignored.
        @(negedge clk);
        req_valid = 1'b1; opcode = 7'b0110011; funct3 = FNC_LW; addr = 32'h1000;
        #1;
        chk("nonload_mem_re", re1, 0);
        @(negedge clk);
        req_valid = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            chk($sformatf("nonload_rv_k%0d", k), rv1, 0);
            chk($sformatf("nonload_ready_k%0d", k), rdy1, 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
